// File: rtl/pmp_fault_ctrl_if.sv
// Request/fault bundle between the request pipeline, trap unit and pmp_fault_ctrl.
// PMP_FAULT_CNT_EN adds the per-cause fault counter signals.
interface pmp_fault_ctrl_if #(
    parameter int REQ_CHANNEL_NUM = 3,
    parameter int ADDR_WIDTH      = 32,
    parameter int CNT_WIDTH       = 16
);
    localparam int CHAN_W = (REQ_CHANNEL_NUM > 1) ? $clog2(REQ_CHANNEL_NUM) : 1;

    logic [REQ_CHANNEL_NUM-1:0]                 v_req_vld;
    logic [REQ_CHANNEL_NUM-1:0][ADDR_WIDTH-1:0] v_req_addr;
    logic [REQ_CHANNEL_NUM-1:0][1:0]            v_req_mode;
    logic [REQ_CHANNEL_NUM-1:0]                 v_pass;
    logic                                       flush;
    logic                                       ovf_clr;
    logic                                       req_stall;
    logic                                       fault_vld;
    logic                                       fault_rdy;
    logic [3:0]                                 fault_cause;
    logic [ADDR_WIDTH-1:0]                      fault_tval;
    logic [CHAN_W-1:0]                          fault_chan;
    logic                                       fault_ovf;
`ifdef PMP_FAULT_CNT_EN
    logic                                       cnt_clr;
    logic [CNT_WIDTH-1:0]                       fault_cnt_inst;
    logic [CNT_WIDTH-1:0]                       fault_cnt_load;
    logic [CNT_WIDTH-1:0]                       fault_cnt_store;

    modport slave (
        input  v_req_vld, v_req_addr, v_req_mode, v_pass, flush, ovf_clr, fault_rdy, cnt_clr,
        output req_stall, fault_vld, fault_cause, fault_tval, fault_chan, fault_ovf,
               fault_cnt_inst, fault_cnt_load, fault_cnt_store
    );
    modport master (
        output v_req_vld, v_req_addr, v_req_mode, v_pass, flush, ovf_clr, fault_rdy, cnt_clr,
        input  req_stall, fault_vld, fault_cause, fault_tval, fault_chan, fault_ovf,
               fault_cnt_inst, fault_cnt_load, fault_cnt_store
    );
`else
    modport slave (
        input  v_req_vld, v_req_addr, v_req_mode, v_pass, flush, ovf_clr, fault_rdy,
        output req_stall, fault_vld, fault_cause, fault_tval, fault_chan, fault_ovf
    );
    modport master (
        output v_req_vld, v_req_addr, v_req_mode, v_pass, flush, ovf_clr, fault_rdy,
        input  req_stall, fault_vld, fault_cause, fault_tval, fault_chan, fault_ovf
    );
`endif
endinterface

// File: rtl/pmp_fault_ctrl.sv
// Turns PMP check failures into access-fault trap records queued in a multi-write FIFO.
// Optional per-cause saturating fault counters are enabled with PMP_FAULT_CNT_EN.
module pmp_fault_ctrl #(
    parameter int REQ_CHANNEL_NUM = 3,
    parameter int ADDR_WIDTH      = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    pmp_fault_ctrl_if.slave bus
);
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int CHAN_W = (REQ_CHANNEL_NUM > 1) ? $clog2(REQ_CHANNEL_NUM) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] NCH_C   = CW'(REQ_CHANNEL_NUM);

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_ovf;
    logic [3:0]            r_mem_cause [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_mem_tval  [FIFO_DEPTH];
    logic [CHAN_W-1:0]     r_mem_chan  [FIFO_DEPTH];

    logic [REQ_CHANNEL_NUM-1:0] w_flt;
    logic [PW-1:0]              w_slot [REQ_CHANNEL_NUM];
    logic [CW-1:0]              w_n;
    logic [CW-1:0]              w_space;
    logic                       w_vld;
    logic                       w_pop;
    logic                       w_fits;
    logic                       w_write;
    logic                       w_drop;

    function automatic logic [3:0] f_cause(input logic [1:0] mode);
        case (mode)
            2'b11:   f_cause = 4'd1;
            2'b01:   f_cause = 4'd5;
            2'b10:   f_cause = 4'd7;
            default: f_cause = 4'd0;
        endcase
    endfunction

    // Faulting channels pack into consecutive slots in ascending channel order.
    always_comb begin
        w_flt = '0;
        w_n   = '0;
        for (int unsigned i = 0; i < REQ_CHANNEL_NUM; i++) begin
            w_flt[i]  = bus.v_req_vld[i] & ~bus.v_pass[i] & (bus.v_req_mode[i] != 2'b00);
            w_slot[i] = r_wr_ptr + w_n[PW-1:0];
            if (w_flt[i]) begin
                w_n = w_n + CW'(1);
            end
        end
    end

    assign w_vld   = (r_count != '0);
    assign w_pop   = w_vld & bus.fault_rdy;
    assign w_space = DEPTH_C - r_count + CW'(w_pop);
    assign w_fits  = (w_n <= w_space);
    assign w_write = ~bus.flush & (w_n != '0) & w_fits;
    assign w_drop  = ~bus.flush & ~w_fits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + w_n[PW-1:0];
            end
            r_count <= r_count + (w_write ? w_n : '0) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // Entry storage carries no reset; the head is gated by fault_vld.
    always_ff @(posedge clk) begin
        if (w_write) begin
            for (int unsigned i = 0; i < REQ_CHANNEL_NUM; i++) begin
                if (w_flt[i]) begin
                    r_mem_cause[w_slot[i]] <= f_cause(bus.v_req_mode[i]);
                    r_mem_tval[w_slot[i]]  <= bus.v_req_addr[i];
                    r_mem_chan[w_slot[i]]  <= CHAN_W'(i);
                end
            end
        end
    end

    assign bus.fault_vld   = w_vld;
    assign bus.fault_cause = w_vld ? r_mem_cause[r_rd_ptr] : '0;
    assign bus.fault_tval  = w_vld ? r_mem_tval[r_rd_ptr] : '0;
    assign bus.fault_chan  = w_vld ? r_mem_chan[r_rd_ptr] : '0;
    assign bus.fault_ovf   = r_ovf;
    assign bus.req_stall   = ((DEPTH_C - r_count) < NCH_C);

`ifdef PMP_FAULT_CNT_EN
    logic [CW-1:0]        w_k_inst;
    logic [CW-1:0]        w_k_load;
    logic [CW-1:0]        w_k_store;
    logic [CNT_WIDTH-1:0] r_cnt_inst;
    logic [CNT_WIDTH-1:0] r_cnt_load;
    logic [CNT_WIDTH-1:0] r_cnt_store;

    function automatic logic [CNT_WIDTH-1:0] f_sat_add(input logic [CNT_WIDTH-1:0] c,
                                                       input logic [CW-1:0] k);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, c} + (CNT_WIDTH+1)'(k);
        f_sat_add = s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    always_comb begin
        w_k_inst  = '0;
        w_k_load  = '0;
        w_k_store = '0;
        for (int unsigned i = 0; i < REQ_CHANNEL_NUM; i++) begin
            if (w_flt[i]) begin
                case (bus.v_req_mode[i])
                    2'b11:   w_k_inst  = w_k_inst + CW'(1);
                    2'b01:   w_k_load  = w_k_load + CW'(1);
                    2'b10:   w_k_store = w_k_store + CW'(1);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_inst  <= '0;
            r_cnt_load  <= '0;
            r_cnt_store <= '0;
        end else if (bus.cnt_clr) begin
            r_cnt_inst  <= '0;
            r_cnt_load  <= '0;
            r_cnt_store <= '0;
        end else if (w_write) begin
            r_cnt_inst  <= f_sat_add(r_cnt_inst, w_k_inst);
            r_cnt_load  <= f_sat_add(r_cnt_load, w_k_load);
            r_cnt_store <= f_sat_add(r_cnt_store, w_k_store);
        end
    end

    assign bus.fault_cnt_inst  = r_cnt_inst;
    assign bus.fault_cnt_load  = r_cnt_load;
    assign bus.fault_cnt_store = r_cnt_store;
`endif
endmodule

// File: doc/pmp_fault_ctrl.md
# pmp_fault_ctrl

Downstream consumer of the PMP checker's per-channel pass vector. It qualifies each checked request with its valid, detects access faults, and converts them into RISC-V access-fault trap records with cause and tval. Records are buffered in a small multi-write FIFO and handed to the trap unit over a valid/ready handshake, with back-pressure to the request pipeline.

## Interface
Parameters:
- REQ_CHANNEL_NUM, 3, number of checked request channels; must equal the PMP checker's channel count.
- ADDR_WIDTH, 32, request address width; also the tval width.
- FIFO_DEPTH, 4, fault record entries; power of 2, >= REQ_CHANNEL_NUM.
- CNT_WIDTH, 16, fault counter width; used only with PMP_FAULT_CNT_EN.

Ports:
- clk  in  1  clock; one clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- v_req_vld  in  REQ_CHANNEL_NUM  per-channel request valid.
- v_req_addr  in  ADDR_WIDTH x REQ_CHANNEL_NUM  request address; the same value driven to the checker.
- v_req_mode  in  2 x REQ_CHANNEL_NUM  access type: 01 load, 10 store, 11 fetch, 00 none.
- v_pass  in  REQ_CHANNEL_NUM  checker result; 1 means permitted.
- flush  in  1  discard all queued faults.
- ovf_clr  in  1  clear the sticky overflow flag.
- req_stall  out  REQ_CHANNEL_NUM-free-slot back-pressure to the request pipeline.
- fault_vld  out  1  FIFO head valid.
- fault_rdy  in  1  trap unit accepts the head record.
- fault_cause  out  4  1 = instruction access fault, 5 = load access fault, 7 = store/AMO access fault.
- fault_tval  out  ADDR_WIDTH  faulting address.
- fault_chan  out  $clog2(REQ_CHANNEL_NUM)  index of the originating channel.
- fault_ovf  out  1  sticky flag: faults were dropped.
- With PMP_FAULT_CNT_EN only:
  - cnt_clr  in  1  clear all fault counters.
  - fault_cnt_inst  out  CNT_WIDTH  instruction fault count.
  - fault_cnt_load  out  CNT_WIDTH  load fault count.
  - fault_cnt_store  out  CNT_WIDTH  store fault count.

## Operation
- Fault detect, per channel i, combinational: flt[i] = v_req_vld[i] & ~v_pass[i] & (v_req_mode[i] != 00).
  - Mode 00 never faults, even when valid.
- Cause map: 11 -> 1, 01 -> 5, 10 -> 7.
- FIFO storage: circular, wr_ptr/rd_ptr of $clog2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH, plus count of $clog2(FIFO_DEPTH)+1 bits.
- Each entry holds {cause, tval, chan}.
- Multi-write enqueue: n = popcount(flt). Available space = FIFO_DEPTH - count + pop, where pop = fault_vld & fault_rdy.
  - n <= space: all faulting channels are written in ascending channel order at wr_ptr, wr_ptr+1, ...
  - n > space: nothing is written this cycle (all-or-none) and fault_ovf sets.
- Dequeue: pop advances rd_ptr by one.
- Count update: count_next = count + (written ? n : 0) - pop.
- Head outputs: fault_cause, fault_tval and fault_chan come straight from the head entry registers. When fault_vld = 0 they read 0.
- fault_vld = (count != 0).
- req_stall = (FIFO_DEPTH - count) < REQ_CHANNEL_NUM. Combinational from the registered count; does not include the current-cycle pop.
- flush:
  - Next edge: count = 0, rd_ptr = wr_ptr = 0.
  - Wins over enqueue and dequeue in the same cycle; faults present that cycle are discarded without setting fault_ovf.
- fault_ovf: set by a drop, cleared by ovf_clr. Set wins if both occur in the same cycle. Not affected by flush.

## Timing
- Reset (async):
  - count, pointers and fault_ovf go to 0.
  - All outputs read 0: fault_vld, fault_cause, fault_tval, fault_chan, fault_ovf, counters. req_stall = 0.
- Latency: a fault on input cycle T gives fault_vld = 1 with its record at cycle T+1, when the FIFO was empty.
- Handshake:
  - A record transfers on each edge with fault_vld & fault_rdy.
  - Head outputs stay stable while fault_vld & ~fault_rdy.
  - fault_rdy is allowed high while fault_vld = 0; no effect.
- Throughput: one pop per cycle. Up to REQ_CHANNEL_NUM pushes per cycle.
- Full with pop on the same cycle: space includes the pop, so a single push is accepted.
- Reset asserted mid-transfer: queued records are lost; no handshake completes.

## Configuration
- PMP_FAULT_CNT_EN defined:
  - Three saturating CNT_WIDTH counters, one per cause.
  - Each counts the entries actually written: +k for k same-cause faults in one cycle, saturating at all-ones.
  - Dropped and flushed faults are not counted.
  - cnt_clr zeroes all three next edge and wins over increments in the same cycle.
- PMP_FAULT_CNT_EN undefined: the counter logic and the cnt_clr / fault_cnt_* ports are absent.

## Test plan
- Single load fault: ch1 vld, mode 01, pass 0, addr 0x8000_1000 -> next cycle fault_vld = 1, cause 5, tval 0x8000_1000, chan 1. Pops with fault_rdy = 1; fault_vld then falls.
- Mode 00 and pass: ch0 vld, mode 00, pass 0; ch2 vld, mode 11, pass 1 -> no enqueue; fault_vld stays 0.
- Simultaneous faults: all 3 channels fault (fetch 0x100, load 0x200, store 0x300), FIFO empty, fault_rdy = 0 -> count = 3, req_stall = 1. Pops return causes 1, 5, 7 in channel order 0, 1, 2.
- Overflow: count = 3, fault_rdy = 0, 2 faults -> nothing written, fault_ovf = 1, count stays 3. ovf_clr -> fault_ovf = 0.
- Full with pop: count = 4, fault_rdy = 1, 1 fault -> accepted, count stays 4, fault_ovf stays 0.
- Flush priority: count = 2, flush together with 1 new fault and fault_rdy = 1 -> count = 0, fault_vld = 0, fault_ovf unchanged. With PMP_FAULT_CNT_EN: counters saturate at 0xFFFF after 65535 load faults, and cnt_clr returns them to 0.
